lcd_panel_ctrl: RTL and testbench
=================================

# lcd_panel_ctrl

Power-up sequencer and configuration controller for the RGB LCD path. After reset it releases the shared 24-bit RGB bus and reads the panel ID straps (R7/G7/B7). It debounces the ID and decodes it into pixel-clock select and h/v timing parameters for the timing driver. It then runs the panel reset, driver-enable and backlight sequence. It sits between the top-level tristate pads and the LCD timing/colorbar driver.

## Interface
- SETTLE_CYC, 1000: cycles with the bus released before the first ID sample.
- SAMPLE_GAP, 100: cycles between ID samples.
- MAX_TRIES, 8: sample attempts before the ID is declared unreadable.
- RST_CYC, 500: cycles `lcd_rst` is held low.
- PON_CYC, 1000: cycles from `lcd_rst` release to `drv_en`.
- BL_CYC, 2000: cycles from `drv_en` to `lcd_bl`.
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  reset: asynchronous assertion, active-high.
- reid  in  1  single-cycle pulse; restarts ID read. Honoured only in RUN and BL_ON.
- rgb_in  in  24  pad input {R[7:0],G[7:0],B[7:0]}.
- rgb_oe  out  1  1 = driver owns the bus; 0 = pads tristated.
- lcd_id  out  16  decoded panel ID.
- id_valid  out  1  high once ID and timing are latched.
- id_err  out  1  ID unstable or unknown; default timing in use.
- clk_sel  out  2  pixel clock select: 0 = 10 MHz, 1 = 33 MHz, 2 = 50 MHz, 3 = 70 MHz.
- h_sync, h_back, h_disp, h_total  out  11 each  horizontal timing, in pixel clocks.
- v_sync, v_back, v_disp, v_total  out  11 each  vertical timing, in lines.
- lcd_rst  out  1  panel reset, active-low.
- drv_en  out  1  enables the timing driver.
- lcd_bl  out  1  backlight enable.

## Operation
- States: SETTLE → SAMPLE → DECODE → PRST → PON → RUN → BL_ON.
- SETTLE
  - `rgb_oe` = 0, `lcd_rst` = 0.
  - Counts SETTLE_CYC, then enters SAMPLE.
- SAMPLE
  - Captures m = {B7 (`rgb_in[7]`), G7 (`rgb_in[15]`), R7 (`rgb_in[23]`)} every SAMPLE_GAP cycles. The first capture happens on entry.
  - Three consecutive equal captures → DECODE.
  - A capture differing from the previous one resets the match count to 1.
  - After MAX_TRIES captures without 3 matches → DECODE with `id_err` = 1 and m forced to 000.
- DECODE (1 cycle) registers the table values plus `id_valid` = 1.
  - m = 000 → `lcd_id` 0x4342, 480×272. h: 41/2/480/525, v: 10/2/272/286, `clk_sel` 0.
  - m = 001 → 0x7084, 800×480. h: 128/88/800/1056, v: 2/33/480/525, `clk_sel` 1.
  - m = 010 → 0x7016, 1024×600. h: 20/140/1024/1344, v: 3/20/600/635, `clk_sel` 2.
  - m = 100 → 0x4384. Same timing as 0x7084, `clk_sel` 1.
  - m = 101 → 0x1018, 1280×800. h: 10/80/1280/1440, v: 3/10/800/823, `clk_sel` 3.
  - Any other m → 0x4342 entry, `id_err` = 1.
- PRST
  - `lcd_rst` = 0 for RST_CYC, then PON.
- PON
  - `lcd_rst` = 1, `rgb_oe` = 1.
  - Counts PON_CYC, then RUN.
- RUN
  - `drv_en` = 1.
  - Counts BL_CYC, then BL_ON (`lcd_bl` = 1).
- `reid` in RUN or BL_ON → SETTLE.
  - Same cycle: `drv_en`, `lcd_bl`, `rgb_oe`, `id_valid`, `id_err` all → 0 and `lcd_rst` → 0.
  - Timing outputs keep their last values until the next DECODE.
- `reid` in any other state is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state SETTLE.
  - `rgb_oe` 0, `lcd_rst` 0, `drv_en` 0, `lcd_bl` 0, `id_valid` 0, `id_err` 0.
  - `lcd_id` 0x0000.
  - Timing outputs hold the 0x4342 entry; `clk_sel` 0.
- `rgb_in` is double-flopped before capture. The bus must be stable at least 2 cycles before each capture point.
- `id_valid` rises 1 cycle after the third matching capture, or after the MAX_TRIES-th capture.
- Timing outputs are valid in the same cycle `id_valid` rises.
- `rgb_oe` rises exactly RST_CYC+1 cycles after `id_valid`, together with `lcd_rst` = 1.
- `drv_en` rises PON_CYC cycles after `rgb_oe`. `lcd_bl` rises BL_CYC cycles after `drv_en`.
- `rgb_oe` is never 1 while the state is SETTLE or SAMPLE. This is a bus-contention invariant.
- `sys_rst` mid-operation: all outputs return to reset values immediately (asynchronous). The sequence restarts from SETTLE on the first clock after release.
- All counters are sized for their parameter (`$clog2`). Counters never wrap.

## Structure
- Package `lcd_pkg`:
  - state enum;
  - ID constants;
  - timing-record struct (clk_sel, h×4, v×4);
  - default (0x4342) record.
- Sub-module `lcd_id_decode`: combinational 3-bit m → {id, record, known} lookup, instantiated once. All other logic (FSM, the single shared down-counter, sampler) lives in `lcd_panel_ctrl`.

## Test plan
- `rgb_in` = 24'h000080 (m = 100), small parameters:
  - `lcd_id` = 0x4384, `h_total` = 1056, `v_total` = 525, `clk_sel` = 1, `id_err` = 0;
  - `rgb_oe` / `drv_en` / `lcd_bl` rise at the specified offsets.
- `rgb_in` = 24'h000000 → `lcd_id` 0x4342, `h_disp` 480, `v_disp` 272, `clk_sel` 0.
- `rgb_in` = 24'h808000 (m = 011) → `lcd_id` 0x4342, `id_err` = 1, sequence still completes to BL_ON.
- `rgb_in[7]` toggled every capture for all MAX_TRIES captures → exactly MAX_TRIES captures, then `id_err` = 1 with default timing.
  - `rgb_oe` is never high before PON.
- In BL_ON, pulse `reid` with `rgb_in` changed to 24'h808080 (m = 111):
  - same cycle: `drv_en`, `lcd_bl`, `rgb_oe` drop;
  - after re-sampling, `lcd_id` 0x4342 with `id_err` = 1.
- Assert `sys_rst` during PON: all outputs are at reset values before the next clock edge; full re-read after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD power-up sequencer: FSM states, panel IDs and the
// timing record handed to the timing driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    StSettle,
    StSample,
    StDecode,
    StPrst,
    StPon,
    StRun,
    StBlOn
  } state_e;

  localparam logic [15:0] Id4342 = 16'h4342;
  localparam logic [15:0] Id7084 = 16'h7084;
  localparam logic [15:0] Id7016 = 16'h7016;
  localparam logic [15:0] Id4384 = 16'h4384;
  localparam logic [15:0] Id1018 = 16'h1018;

  typedef struct packed {
    logic [1:0]  clk_sel;
    logic [10:0] h_sync;
    logic [10:0] h_back;
    logic [10:0] h_disp;
    logic [10:0] h_total;
    logic [10:0] v_sync;
    logic [10:0] v_back;
    logic [10:0] v_disp;
    logic [10:0] v_total;
  } timing_t;

  localparam timing_t Timing480 = '{
    clk_sel: 2'd0,
    h_sync: 11'd41, h_back: 11'd2, h_disp: 11'd480, h_total: 11'd525,
    v_sync: 11'd10, v_back: 11'd2, v_disp: 11'd272, v_total: 11'd286
  };

  localparam timing_t Timing800 = '{
    clk_sel: 2'd1,
    h_sync: 11'd128, h_back: 11'd88, h_disp: 11'd800, h_total: 11'd1056,
    v_sync: 11'd2, v_back: 11'd33, v_disp: 11'd480, v_total: 11'd525
  };

  localparam timing_t Timing1024 = '{
    clk_sel: 2'd2,
    h_sync: 11'd20, h_back: 11'd140, h_disp: 11'd1024, h_total: 11'd1344,
    v_sync: 11'd3, v_back: 11'd20, v_disp: 11'd600, v_total: 11'd635
  };

  localparam timing_t Timing1280 = '{
    clk_sel: 2'd3,
    h_sync: 11'd10, h_back: 11'd80, h_disp: 11'd1280, h_total: 11'd1440,
    v_sync: 11'd3, v_back: 11'd10, v_disp: 11'd800, v_total: 11'd823
  };

  // Fallback used at reset and for unreadable or unknown straps.
  localparam timing_t TimingDefault = Timing480;

endpackage

// File: rtl/lcd_id_decode.sv
// Combinational lookup from the 3-bit strap code to panel ID and timing record.
module lcd_id_decode
  import lcd_pkg::*;
(
  input  logic [2:0]  i_m,
  output logic [15:0] o_id,
  output timing_t     o_timing,
  output logic        o_known
);

  always_comb begin
    o_id     = Id4342;
    o_timing = TimingDefault;
    o_known  = 1'b0;
    case (i_m)
      3'b000: o_known = 1'b1;
      3'b001: begin
        o_id     = Id7084;
        o_timing = Timing800;
        o_known  = 1'b1;
      end
      3'b010: begin
        o_id     = Id7016;
        o_timing = Timing1024;
        o_known  = 1'b1;
      end
      3'b100: begin
        o_id     = Id4384;
        o_timing = Timing800;
        o_known  = 1'b1;
      end
      3'b101: begin
        o_id     = Id1018;
        o_timing = Timing1280;
        o_known  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_panel_ctrl.sv
// Panel power-up sequencer: releases the RGB bus, debounces the ID straps, latches timing,
// then walks panel reset, driver enable and backlight using one shared down-counter.
module lcd_panel_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1000,
  parameter int unsigned SAMPLE_GAP = 100,
  parameter int unsigned MAX_TRIES  = 8,
  parameter int unsigned RST_CYC    = 500,
  parameter int unsigned PON_CYC    = 1000,
  parameter int unsigned BL_CYC     = 2000
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_reid,
  input  logic [23:0] i_rgb_in,
  output logic        o_rgb_oe,
  output logic [15:0] o_lcd_id,
  output logic        o_id_valid,
  output logic        o_id_err,
  output logic [1:0]  o_clk_sel,
  output logic [10:0] o_h_sync,
  output logic [10:0] o_h_back,
  output logic [10:0] o_h_disp,
  output logic [10:0] o_h_total,
  output logic [10:0] o_v_sync,
  output logic [10:0] o_v_back,
  output logic [10:0] o_v_disp,
  output logic [10:0] o_v_total,
  output logic        o_lcd_rst,
  output logic        o_drv_en,
  output logic        o_lcd_bl
);

  localparam int unsigned Max1   = (SETTLE_CYC > SAMPLE_GAP) ? SETTLE_CYC : SAMPLE_GAP;
  localparam int unsigned Max2   = (RST_CYC > PON_CYC) ? RST_CYC : PON_CYC;
  localparam int unsigned Max3   = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned MaxCyc = (Max3 > BL_CYC) ? Max3 : BL_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned TryW   = $clog2(MAX_TRIES + 1);

  localparam logic [CntW-1:0] SettleLd  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] GapLd     = CntW'(SAMPLE_GAP - 1);
  localparam logic [CntW-1:0] RstLd     = CntW'(RST_CYC - 1);
  localparam logic [CntW-1:0] PonLd     = CntW'(PON_CYC - 1);
  localparam logic [CntW-1:0] BlLd      = CntW'(BL_CYC - 1);
  localparam logic [TryW-1:0] TriesLast = TryW'(MAX_TRIES);

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [2:0]      r_sync1, r_sync2, r_prev_m, r_dec_m;
  logic [TryW-1:0] r_tries, w_tries_d;
  logic [1:0]      r_match, w_match_d;
  logic            r_samp_err;
  logic            w_capture, w_reid_hit, w_locked, w_exhausted;

  logic [15:0]     w_dec_id;
  timing_t         w_dec_timing;
  logic            w_dec_known;

  logic            r_rgb_oe, r_lcd_rst, r_drv_en, r_lcd_bl, r_id_valid, r_id_err;
  logic            w_rgb_oe_d, w_lcd_rst_d, w_drv_en_d, w_lcd_bl_d, w_id_valid_d, w_id_err_d;
  logic [15:0]     r_lcd_id, w_lcd_id_d;
  timing_t         r_timing, w_timing_d;

  logic            w_unused_rgb;
  assign w_unused_rgb = ^{i_rgb_in[22:16], i_rgb_in[14:8], i_rgb_in[6:0]};

  assign w_reid_hit  = i_reid && (r_state == StRun || r_state == StBlOn);
  assign w_capture   = (r_state == StSample) && (r_cnt == '0);
  assign w_match_d   = ((r_tries != '0) && (r_sync2 == r_prev_m)) ? r_match + 2'd1 : 2'd1;
  assign w_tries_d   = r_tries + TryW'(1);
  assign w_locked    = (w_match_d == 2'd3);
  assign w_exhausted = (w_tries_d == TriesLast);

  lcd_id_decode u_id_decode (
    .i_m      (r_dec_m),
    .o_id     (w_dec_id),
    .o_timing (w_dec_timing),
    .o_known  (w_dec_known)
  );

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state <= StSettle;
      r_cnt   <= SettleLd;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = (r_cnt != '0) ? r_cnt - CntW'(1) : r_cnt;
    unique case (r_state)
      StSettle: begin
        if (r_cnt == '0) begin
          w_state_d = StSample;
          w_cnt_d   = '0;
        end
      end
      StSample: begin
        if (w_capture) begin
          if (w_locked || w_exhausted) w_state_d = StDecode;
          else                         w_cnt_d   = GapLd;
        end
      end
      StDecode: begin
        w_state_d = StPrst;
        w_cnt_d   = RstLd;
      end
      StPrst: begin
        if (r_cnt == '0) begin
          w_state_d = StPon;
          w_cnt_d   = PonLd;
        end
      end
      StPon: begin
        if (r_cnt == '0) begin
          w_state_d = StRun;
          w_cnt_d   = BlLd;
        end
      end
      StRun: begin
        if (r_cnt == '0) w_state_d = StBlOn;
      end
      StBlOn: ;
      default: w_state_d = StSettle;
    endcase
    if (w_reid_hit) begin
      w_state_d = StSettle;
      w_cnt_d   = SettleLd;
    end
  end

  // Straps pass two flops before capture; an unresolved run decodes as code 000 with error.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev_m   <= '0;
      r_dec_m    <= '0;
      r_tries    <= '0;
      r_match    <= '0;
      r_samp_err <= 1'b0;
    end else begin
      r_sync1 <= {i_rgb_in[7], i_rgb_in[15], i_rgb_in[23]};
      r_sync2 <= r_sync1;
      if (r_state == StSettle) begin
        r_tries <= '0;
        r_match <= '0;
      end else if (w_capture) begin
        r_prev_m   <= r_sync2;
        r_tries    <= w_tries_d;
        r_match    <= w_match_d;
        r_dec_m    <= w_locked ? r_sync2 : 3'b000;
        r_samp_err <= !w_locked;
      end
    end
  end

  always_comb begin
    w_rgb_oe_d   = 1'b0;
    w_lcd_rst_d  = 1'b0;
    w_drv_en_d   = 1'b0;
    w_lcd_bl_d   = 1'b0;
    w_id_valid_d = 1'b0;
    w_id_err_d   = r_id_err;
    w_lcd_id_d   = r_lcd_id;
    w_timing_d   = r_timing;
    unique case (r_state)
      StDecode: begin
        w_id_valid_d = 1'b1;
        w_id_err_d   = r_samp_err | ~w_dec_known;
        w_lcd_id_d   = w_dec_id;
        w_timing_d   = w_dec_timing;
      end
      StPrst: w_id_valid_d = 1'b1;
      StPon: begin
        w_id_valid_d = 1'b1;
        w_rgb_oe_d   = 1'b1;
        w_lcd_rst_d  = 1'b1;
      end
      StRun: begin
        w_id_valid_d = 1'b1;
        w_rgb_oe_d   = 1'b1;
        w_lcd_rst_d  = 1'b1;
        w_drv_en_d   = 1'b1;
      end
      StBlOn: begin
        w_id_valid_d = 1'b1;
        w_rgb_oe_d   = 1'b1;
        w_lcd_rst_d  = 1'b1;
        w_drv_en_d   = 1'b1;
        w_lcd_bl_d   = 1'b1;
      end
      default: ;
    endcase
    // Re-read drops bus and panel together; timing and ID hold until the next decode.
    if (w_reid_hit) begin
      w_rgb_oe_d   = 1'b0;
      w_lcd_rst_d  = 1'b0;
      w_drv_en_d   = 1'b0;
      w_lcd_bl_d   = 1'b0;
      w_id_valid_d = 1'b0;
      w_id_err_d   = 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_rgb_oe   <= 1'b0;
      r_lcd_rst  <= 1'b0;
      r_drv_en   <= 1'b0;
      r_lcd_bl   <= 1'b0;
      r_id_valid <= 1'b0;
      r_id_err   <= 1'b0;
      r_lcd_id   <= '0;
      r_timing   <= TimingDefault;
    end else begin
      r_rgb_oe   <= w_rgb_oe_d;
      r_lcd_rst  <= w_lcd_rst_d;
      r_drv_en   <= w_drv_en_d;
      r_lcd_bl   <= w_lcd_bl_d;
      r_id_valid <= w_id_valid_d;
      r_id_err   <= w_id_err_d;
      r_lcd_id   <= w_lcd_id_d;
      r_timing   <= w_timing_d;
    end
  end

  assign o_rgb_oe   = r_rgb_oe;
  assign o_lcd_rst  = r_lcd_rst;
  assign o_drv_en   = r_drv_en;
  assign o_lcd_bl   = r_lcd_bl;
  assign o_id_valid = r_id_valid;
  assign o_id_err   = r_id_err;
  assign o_lcd_id   = r_lcd_id;
  assign o_clk_sel  = r_timing.clk_sel;
  assign o_h_sync   = r_timing.h_sync;
  assign o_h_back   = r_timing.h_back;
  assign o_h_disp   = r_timing.h_disp;
  assign o_h_total  = r_timing.h_total;
  assign o_v_sync   = r_timing.v_sync;
  assign o_v_back   = r_timing.v_back;
  assign o_v_disp   = r_timing.v_disp;
  assign o_v_total  = r_timing.v_total;

endmodule

// File: tb/tb_lcd_panel_ctrl.sv
// Randomized bench for lcd_panel_ctrl: per-capture strap sequences are scored against a
// table-and-timeline model of the power-up sequence.
module tb_lcd_panel_ctrl;

  localparam int S = 20;
  localparam int G = 10;
  localparam int T = 8;
  localparam int R = 5;
  localparam int P = 7;
  localparam int B = 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reid = 1'b0;
  logic [23:0] rgb = '0;
  logic        o_rgb_oe, o_id_valid, o_id_err, o_lcd_rst, o_drv_en, o_lcd_bl;
  logic [15:0] o_lcd_id;
  logic [1:0]  o_clk_sel;
  logic [10:0] o_h_sync, o_h_back, o_h_disp, o_h_total;
  logic [10:0] o_v_sync, o_v_back, o_v_disp, o_v_total;

  int          total = 0;
  int          bad = 0;
  logic [2:0]  g_ms [T];
  logic [43:0] g_last_h;

  always #5 clk = ~clk;

  lcd_panel_ctrl #(
    .SETTLE_CYC (S),
    .SAMPLE_GAP (G),
    .MAX_TRIES  (T),
    .RST_CYC    (R),
    .PON_CYC    (P),
    .BL_CYC     (B)
  ) dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .i_reid     (reid),
    .i_rgb_in   (rgb),
    .o_rgb_oe   (o_rgb_oe),
    .o_lcd_id   (o_lcd_id),
    .o_id_valid (o_id_valid),
    .o_id_err   (o_id_err),
    .o_clk_sel  (o_clk_sel),
    .o_h_sync   (o_h_sync),
    .o_h_back   (o_h_back),
    .o_h_disp   (o_h_disp),
    .o_h_total  (o_h_total),
    .o_v_sync   (o_v_sync),
    .o_v_back   (o_v_back),
    .o_v_disp   (o_v_disp),
    .o_v_total  (o_v_total),
    .o_lcd_rst  (o_lcd_rst),
    .o_drv_en   (o_drv_en),
    .o_lcd_bl   (o_lcd_bl)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] obs_h();
    return {o_h_sync, o_h_back, o_h_disp, o_h_total};
  endfunction

  function automatic logic [43:0] obs_v();
    return {o_v_sync, o_v_back, o_v_disp, o_v_total};
  endfunction

  // Panel table: strap code -> ID, clock select, h and v timing, known flag.
  task automatic lookup(input logic [2:0] m, output logic [15:0] id, output logic [1:0] cs,
                        output logic [43:0] h, output logic [43:0] v, output bit known);
    id = 16'h4342; cs = 2'd0; known = 1'b0;
    h  = {11'd41, 11'd2, 11'd480, 11'd525};
    v  = {11'd10, 11'd2, 11'd272, 11'd286};
    case (m)
      3'b000: known = 1'b1;
      3'b001, 3'b100: begin
        id = (m == 3'b001) ? 16'h7084 : 16'h4384; cs = 2'd1; known = 1'b1;
        h  = {11'd128, 11'd88, 11'd800, 11'd1056};
        v  = {11'd2, 11'd33, 11'd480, 11'd525};
      end
      3'b010: begin
        id = 16'h7016; cs = 2'd2; known = 1'b1;
        h  = {11'd20, 11'd140, 11'd1024, 11'd1344};
        v  = {11'd3, 11'd20, 11'd600, 11'd635};
      end
      3'b101: begin
        id = 16'h1018; cs = 2'd3; known = 1'b1;
        h  = {11'd10, 11'd80, 11'd1280, 11'd1440};
        v  = {11'd3, 11'd10, 11'd800, 11'd823};
      end
      default: ;
    endcase
  endtask

  // First capture index closing three equal captures in a row, else give up after T.
  task automatic decide(output int d, output logic [2:0] mf, output bit serr);
    d = T - 1; mf = 3'b000; serr = 1'b1;
    for (int k = 2; k < T; k++) begin
      if (g_ms[k] == g_ms[k-1] && g_ms[k-1] == g_ms[k-2]) begin
        d = k; mf = g_ms[k]; serr = 1'b0;
        break;
      end
    end
  endtask

  function automatic logic [23:0] mk_rgb(input logic [2:0] m);
    logic [23:0] val;
    val     = 24'($urandom);
    val[23] = m[0];
    val[15] = m[1];
    val[7]  = m[2];
    return val;
  endfunction

  task automatic set_const(input logic [2:0] m);
    for (int k = 0; k < T; k++) g_ms[k] = m;
  endtask

  // Edge 1 is the first clock after reset release or after the edge that took reid.
  task automatic run_seq(input string nm, input bit full, input int stray);
    int d, n, last, e_iv, e_oe, e_en, e_bl, r_iv, r_oe, r_en, r_bl;
    logic [2:0] mf;
    bit serr, known, oe_early;
    logic [15:0] eid;
    logic [1:0] ecs;
    logic [43:0] eh, ev;
    decide(d, mf, serr);
    lookup(mf, eid, ecs, eh, ev, known);
    e_iv = S + 1 + d * G + 1;
    e_oe = e_iv + R + 1;
    e_en = e_oe + P;
    e_bl = e_en + B;
    last = full ? e_bl + 2 : e_oe + 2;
    r_iv = -1; r_oe = -1; r_en = -1; r_bl = -1;
    oe_early = 1'b0;
    n = 0;
    while (n < last) begin
      @(posedge clk);
      n++;
      #1;
      reid = (n == stray);
      if (o_id_valid && r_iv < 0) r_iv = n;
      if (o_rgb_oe && r_oe < 0) r_oe = n;
      if (o_drv_en && r_en < 0) r_en = n;
      if (o_lcd_bl && r_bl < 0) r_bl = n;
      if (o_rgb_oe && n < e_oe) oe_early = 1'b1;
      if (n == e_iv) begin
        check_val({nm, ".id"}, 64'(o_lcd_id), 64'(eid));
        check_val({nm, ".clksel"}, 64'(o_clk_sel), 64'(ecs));
        check_val({nm, ".h"}, 64'(obs_h()), 64'(eh));
        check_val({nm, ".v"}, 64'(obs_v()), 64'(ev));
        check_val({nm, ".err"}, 64'(o_id_err), 64'(serr | !known));
      end
      if (n == e_oe) check_val({nm, ".lcdrst"}, 64'(o_lcd_rst), 64'(1));
      for (int k = 0; k < T - 1; k++)
        if (n == S + 1 + k * G + G / 2) rgb = mk_rgb(g_ms[k+1]);
    end
    reid = 1'b0;
    g_last_h = eh;
    check_val({nm, ".t_valid"}, 64'(r_iv), 64'(e_iv));
    check_val({nm, ".t_oe"}, 64'(r_oe), 64'(e_oe));
    check_val({nm, ".oe_early"}, 64'(oe_early), 64'(0));
    if (full) begin
      check_val({nm, ".t_drv"}, 64'(r_en), 64'(e_en));
      check_val({nm, ".t_bl"}, 64'(r_bl), 64'(e_bl));
    end
  endtask

  // Expects the DUT in BL_ON; the straps for the re-read are in g_ms.
  task automatic do_reid(input string nm);
    rgb  = mk_rgb(g_ms[0]);
    reid = 1'b1;
    @(posedge clk);
    #1;
    reid = 1'b0;
    check_val({nm, ".drop"},
              64'({o_drv_en, o_lcd_bl, o_rgb_oe, o_id_valid, o_id_err, o_lcd_rst}), 64'(0));
    check_val({nm, ".keep_h"}, 64'(obs_h()), 64'(g_last_h));
  endtask

  // Called between clock edges; checks asynchronous reset before the next edge.
  task automatic do_reset(input string nm);
    rgb = mk_rgb(g_ms[0]);
    #2;
    rst = 1'b1;
    #1;
    check_val({nm, ".ctl"},
              64'({o_rgb_oe, o_lcd_rst, o_drv_en, o_lcd_bl, o_id_valid, o_id_err}), 64'(0));
    check_val({nm, ".id"}, 64'(o_lcd_id), 64'(0));
    check_val({nm, ".tim"}, 64'({o_clk_sel, obs_h(), obs_v()}),
              64'({2'd0, 11'd41, 11'd2, 11'd480, 11'd525, 11'd10, 11'd2, 11'd272, 11'd286}));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] base;
    set_const(3'b100);
    do_reset("por");
    run_seq("m100", 1'b1, -1);

    set_const(3'b000);
    do_reid("r000");
    run_seq("m000", 1'b1, S + 3);

    set_const(3'b011);
    do_reid("r011");
    run_seq("m011", 1'b1, -1);

    for (int k = 0; k < T; k++) g_ms[k] = (k % 2 == 1) ? 3'b100 : 3'b000;
    do_reid("rtog");
    run_seq("tog", 1'b1, -1);

    set_const(3'b111);
    do_reid("r111");
    run_seq("m111", 1'b1, -1);

    set_const(3'b101);
    do_reid("r101");
    run_seq("m101", 1'b0, -1);
    set_const(3'b010);
    do_reset("midrst");
    run_seq("m010", 1'b1, -1);

    for (int i = 0; i < 6; i++) begin
      base = 3'($urandom_range(0, 7));
      for (int k = 0; k < T; k++)
        g_ms[k] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : base;
      do_reid($sformatf("rr%0d", i));
      run_seq($sformatf("rnd%0d", i), 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
